// File: rtl/seq_tx_if.sv
// seq_tx load/abort handshake and serial line bundle.
// master drives the load side, slave is the transmitter.
interface seq_tx_if #(
  parameter int W  = 8,
  parameter int RW = 4
);
  logic          load_valid;
  logic          load_ready;
  logic [W-1:0]  pattern;
  logic [RW-1:0] reps;
  logic          abort;
  logic          dout;
  logic          bit_strobe;
  logic          tx_active;
  logic          done;

  modport master (
    output load_valid, pattern, reps, abort,
    input  load_ready, dout, bit_strobe,
    input  tx_active, done
  );

  modport slave (
    input  load_valid, pattern, reps, abort,
    output load_ready, dout, bit_strobe,
    output tx_active, done
  );
endinterface

// File: rtl/seq_tx.sv
// Serial sequence transmitter, LSB-first, reps+1 copies.
// Define SEQ_TX_STUFF_EN to compile in the CAN-style bit stuffer.
module seq_tx #(
  parameter int W  = 8,
  parameter int RW = 4
`ifdef SEQ_TX_STUFF_EN
  ,
  parameter int STUFF_LEN = 5
`endif
) (
  input  logic   clk,
  input  logic   rst,
  seq_tx_if.slave bus
);

  localparam int BW = $clog2(W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
`ifdef SEQ_TX_STUFF_EN
    STUFF = 2'd2,
`endif
    DONE  = 2'd3
  } state_t;

  state_t        state_q;
  logic [W-1:0]  shreg_q;
  logic [BW-1:0] bit_cnt_q;
  logic [RW-1:0] rep_cnt_q;
  logic          dout_q;
  logic          strobe_q;
  logic          active_q;
  logic          done_q;

  logic          last_d;
  logic          fin_d;
  logic          bit_d;
  logic          stuff_d;
  logic [BW-1:0] cnt_d;
  logic [RW-1:0] rep_d;

`ifdef SEQ_TX_STUFF_EN
  localparam int RNW = $clog2(STUFF_LEN + 1);
  logic [RNW-1:0] run_q;
  logic [RNW-1:0] run_d;
`endif

  // bit_cnt_q indexes the bit currently on the line
  always_comb begin
    last_d  = bit_cnt_q == BW'(W - 1);
    fin_d   = last_d && (rep_cnt_q == '0);
    cnt_d   = last_d ? '0 : bit_cnt_q + 1'b1;
    rep_d   = (last_d && rep_cnt_q != '0)
            ? rep_cnt_q - 1'b1 : rep_cnt_q;
    bit_d   = shreg_q[cnt_d];
`ifdef SEQ_TX_STUFF_EN
    stuff_d = (state_q == SEND)
           && (run_q == RNW'(STUFF_LEN));
    run_d   = (bit_d == dout_q)
            ? run_q + 1'b1 : RNW'(1);
`else
    stuff_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      dout_q    <= 1'b1;
      strobe_q  <= 1'b0;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
`ifdef SEQ_TX_STUFF_EN
      run_q     <= '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.load_valid) begin
            state_q   <= SEND;
            shreg_q   <= bus.pattern;
            rep_cnt_q <= bus.reps;
            bit_cnt_q <= '0;
            dout_q    <= bus.pattern[0];
            strobe_q  <= 1'b1;
            active_q  <= 1'b1;
`ifdef SEQ_TX_STUFF_EN
            run_q     <= RNW'(1);
`endif
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        // SEND, and STUFF when compiled in
        default: begin
          if (bus.abort) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            rep_cnt_q <= '0;
            dout_q    <= 1'b1;
            strobe_q  <= 1'b0;
            active_q  <= 1'b0;
`ifdef SEQ_TX_STUFF_EN
            run_q     <= '0;
`endif
          end else if (stuff_d) begin
`ifdef SEQ_TX_STUFF_EN
            state_q  <= STUFF;
            dout_q   <= ~dout_q;
            strobe_q <= 1'b0;
            run_q    <= RNW'(1);
`endif
          end else if (fin_d) begin
            state_q   <= DONE;
            bit_cnt_q <= '0;
            dout_q    <= 1'b1;
            strobe_q  <= 1'b0;
            active_q  <= 1'b0;
            done_q    <= 1'b1;
`ifdef SEQ_TX_STUFF_EN
            run_q     <= '0;
`endif
          end else begin
            state_q   <= SEND;
            bit_cnt_q <= cnt_d;
            rep_cnt_q <= rep_d;
            dout_q    <= bit_d;
            strobe_q  <= 1'b1;
`ifdef SEQ_TX_STUFF_EN
            run_q     <= run_d;
`endif
          end
        end
      endcase
    end
  end

  assign bus.load_ready = state_q == IDLE;
  assign bus.dout       = dout_q;
  assign bus.bit_strobe = strobe_q;
  assign bus.tx_active  = active_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_seq_tx.sv
// Randomized bench for seq_tx against a queue-based line model.
// Model builds the expected per-cycle line from pattern and reps.
module tb_seq_tx;

  localparam int W  = 8;
  localparam int RW = 4;
  localparam int SL = 5;

  logic clk;
  logic rst;
  int   checks;
  int   fails;

  logic [1:0] exp_q[$];

  seq_tx_if #(.W(W), .RW(RW)) bus ();

  seq_tx #(.W(W), .RW(RW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // entry = {line level, strobe}
  task automatic build(
    input logic [W-1:0] p,
    input int           r
  );
    int   run;
    logic last;
    logic b;
    exp_q.delete();
    run  = 0;
    last = 1'b1;
    for (int c = 0; c <= r; c++) begin
      for (int i = 0; i < W; i++) begin
        b = p[i];
        exp_q.push_back({b, 1'b1});
`ifdef SEQ_TX_STUFF_EN
        if (run > 0 && b == last) run++;
        else run = 1;
        last = b;
        if (run == SL) begin
          last = ~last;
          exp_q.push_back({last, 1'b0});
          run = 1;
        end
`endif
      end
    end
  endtask

  // ab: -1 none, -2 last line bit, else line index
  task automatic frame(
    input logic [W-1:0] p,
    input int           r,
    input int           ab,
    input bit           poke
  );
    int n;
    int abi;
    build(p, r);
    n   = exp_q.size();
    abi = (ab == -2) ? n - 1 : ab;
    chk("pre_rdy", bus.load_ready, 1);
    bus.load_valid = 1'b1;
    bus.pattern    = p;
    bus.reps       = RW'(r);
    @(posedge clk);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) bus.load_valid = 1'b0;
      if (poke && i == 2) begin
        bus.load_valid = 1'b1;
        bus.pattern    = ~p;
        bus.reps       = '1;
      end
      if (poke && i == 3) bus.load_valid = 1'b0;
      chk("dout", bus.dout, exp_q[i][1]);
      chk("strobe", bus.bit_strobe, exp_q[i][0]);
      chk("active", bus.tx_active, 1);
      chk("busy_rdy", bus.load_ready, 0);
      chk("done_lo", bus.done, 0);
      if (i == abi) begin
        bus.abort      = 1'b1;
        bus.load_valid = 1'b0;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("ab_dout", bus.dout, 1);
        chk("ab_active", bus.tx_active, 0);
        chk("ab_strobe", bus.bit_strobe, 0);
        chk("ab_done", bus.done, 0);
        chk("ab_rdy", bus.load_ready, 1);
        return;
      end
    end
    @(negedge clk);
    chk("done_hi", bus.done, 1);
    chk("done_act", bus.tx_active, 0);
    chk("done_dout", bus.dout, 1);
    chk("done_strb", bus.bit_strobe, 0);
    chk("done_rdy", bus.load_ready, 0);
    @(negedge clk);
    chk("post_done", bus.done, 0);
    chk("post_rdy", bus.load_ready, 1);
  endtask

  initial begin
    int r;
    int ab;
    logic [W-1:0] p;
    checks         = 0;
    fails          = 0;
    rst            = 1'b0;
    bus.load_valid = 1'b1;
    bus.pattern    = 8'h55;
    bus.reps       = '0;
    bus.abort      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dout", bus.dout, 1);
    chk("rst_rdy", bus.load_ready, 1);
    chk("rst_done", bus.done, 0);
    chk("rst_act", bus.tx_active, 0);
    chk("rst_strb", bus.bit_strobe, 0);
    bus.load_valid = 1'b0;
    rst            = 1'b1;
    @(negedge clk);
    chk("rel_act", bus.tx_active, 0);

    frame(8'hB4, 0, -1, 1'b0);
    frame(8'hA5, 2, -1, 1'b0);
    frame(8'h0F, 3, 4, 1'b0);
    frame(8'hB4, 0, -1, 1'b0);
    frame(8'hB4, 1, -1, 1'b1);
    frame(8'h3C, 15, -1, 1'b0);
    frame(8'h81, 0, -2, 1'b0);
    frame(8'h00, 0, -1, 1'b0);
    frame(8'hFF, 1, -1, 1'b0);
    frame(8'hE7, 2, 9, 1'b0);

    // async reset in the middle of a frame
    bus.load_valid = 1'b1;
    bus.pattern    = 8'hC3;
    bus.reps       = RW'(1);
    @(negedge clk);
    bus.load_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_act", bus.tx_active, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_act", bus.tx_active, 0);
    chk("arst_dout", bus.dout, 1);
    chk("arst_strb", bus.bit_strobe, 0);
    chk("arst_rdy", bus.load_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("arst_idle", bus.tx_active, 0);

    for (int k = 0; k < 40; k++) begin
      p  = W'($urandom);
      r  = ($urandom_range(0, 7) == 0)
         ? (1 << RW) - 1 : int'($urandom_range(0, 3));
      ab = ($urandom_range(0, 3) == 0)
         ? int'($urandom_range(0, W * (r + 1) - 1)) : -1;
      frame(p, r, ab, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
